// File: rtl/rotary_pkg.sv
// Shared types and helpers for the rotary value controller: acceleration
// state encoding, direction constants and a counter width helper.
package rotary_pkg;

    typedef enum logic {
        ACCEL_SLOW = 1'b0,
        ACCEL_FAST = 1'b1
    } accel_state_e;

    localparam logic DIR_CW  = 1'b1;
    localparam logic DIR_CCW = 1'b0;

    // Bits needed to hold every value in 0..max_val (never less than one).
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/rotary_accel_tracker.sv
// Velocity tracker: gap timer, fast-step streak counter and SLOW/FAST state.
// Produces the increment to apply for the step currently presented.
module rotary_accel_tracker
    import rotary_pkg::*;
#(
    parameter int unsigned VALUE_WIDTH = 8,
    parameter int unsigned FAST_CYCLES = 50000,
    parameter int unsigned STREAK_LEN  = 3,
    parameter int unsigned ACCEL_STEP  = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 step_i,
    input  logic                 dir_i,
    input  logic                 clear_i,
    output logic [VALUE_WIDTH:0] step_size_o,
    output logic                 fast_o
);

    localparam int unsigned TIMER_WIDTH  = cnt_width(FAST_CYCLES);
    localparam int unsigned STREAK_WIDTH = cnt_width(STREAK_LEN);

    localparam logic [TIMER_WIDTH-1:0]  TIMER_SAT  = TIMER_WIDTH'(FAST_CYCLES);
    localparam logic [TIMER_WIDTH-1:0]  TIMER_ONE  = TIMER_WIDTH'(1);
    localparam logic [STREAK_WIDTH-1:0] STREAK_TOP = STREAK_WIDTH'(STREAK_LEN);
    localparam logic [STREAK_WIDTH-1:0] STREAK_ONE = STREAK_WIDTH'(1);
    localparam logic [VALUE_WIDTH:0]    SIZE_ONE   = (VALUE_WIDTH+1)'(1);
    localparam logic [VALUE_WIDTH:0]    SIZE_ACCEL = (VALUE_WIDTH+1)'(ACCEL_STEP);

    accel_state_e            state_q, state_d;
    logic [TIMER_WIDTH-1:0]  timer_q, timer_d;
    logic [STREAK_WIDTH-1:0] streak_q, streak_d;
    logic                    last_dir_q, last_dir_d;

    logic                    hit;
    logic [STREAK_WIDTH-1:0] streak_inc;

    // Judged against the timer as it stood before this edge, so a step on the
    // saturating edge still counts as fast.
    assign hit        = (timer_q < TIMER_SAT) && (dir_i == last_dir_q);
    assign streak_inc = (streak_q < STREAK_TOP) ? streak_q + STREAK_ONE : STREAK_TOP;

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        streak_d    = streak_q;
        last_dir_d  = last_dir_q;
        step_size_o = SIZE_ONE;
        if (clear_i) begin
            timer_d  = TIMER_SAT;
            streak_d = '0;
            state_d  = ACCEL_SLOW;
        end else if (step_i) begin
            timer_d    = '0;
            last_dir_d = dir_i;
            if (hit) begin
                if (state_q == ACCEL_FAST) step_size_o = SIZE_ACCEL;
                streak_d = streak_inc;
                if (streak_inc == STREAK_TOP) state_d = ACCEL_FAST;
            end else begin
                streak_d = '0;
                state_d  = ACCEL_SLOW;
            end
        end else if (timer_q < TIMER_SAT) begin
            timer_d = timer_q + TIMER_ONE;
            if (timer_d == TIMER_SAT) begin
                state_d  = ACCEL_SLOW;
                streak_d = '0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= ACCEL_SLOW;
            timer_q    <= TIMER_SAT;
            streak_q   <= '0;
            last_dir_q <= DIR_CW;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            streak_q   <= streak_d;
            last_dir_q <= last_dir_d;
        end
    end

    assign fast_o = (state_q == ACCEL_FAST);

endmodule

// File: rtl/rotary_value_ctrl.sv
// Bounded user setting driven by encoder detent steps, with saturate or wrap.
// Define ROTARY_VALUE_CTRL_ACCEL_EN to build in velocity-based acceleration.
module rotary_value_ctrl
    import rotary_pkg::*;
#(
    parameter int unsigned VALUE_WIDTH = 8,
    parameter int unsigned VALUE_MIN   = 0,
    parameter int unsigned VALUE_MAX   = 255,
    parameter int unsigned VALUE_INIT  = 0,
    parameter int unsigned WRAP        = 0,
    parameter int unsigned FAST_CYCLES = 50000,
    parameter int unsigned STREAK_LEN  = 3,
    parameter int unsigned ACCEL_STEP  = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_step,
    input  logic                   i_step_cw,
    input  logic                   i_load,
    input  logic [VALUE_WIDTH-1:0] i_load_value,
    output logic [VALUE_WIDTH-1:0] o_value,
    output logic                   o_changed,
    output logic                   o_at_min,
    output logic                   o_at_max,
    output logic                   o_fast
);

    if (!(VALUE_MIN < VALUE_MAX && VALUE_MAX < (2 ** VALUE_WIDTH) &&
          VALUE_INIT + 1 > VALUE_MIN && VALUE_INIT <= VALUE_MAX && WRAP < 2 &&
          FAST_CYCLES > 0 && STREAK_LEN > 0 && ACCEL_STEP > 0 &&
          ACCEL_STEP <= VALUE_MAX - VALUE_MIN + 1)) begin : g_param_check
        $error("rotary_value_ctrl: illegal parameter combination");
    end

    localparam logic [VALUE_WIDTH-1:0] MIN_V   = VALUE_WIDTH'(VALUE_MIN);
    localparam logic [VALUE_WIDTH-1:0] MAX_V   = VALUE_WIDTH'(VALUE_MAX);
    localparam logic [VALUE_WIDTH-1:0] INIT_V  = VALUE_WIDTH'(VALUE_INIT);
    localparam logic [VALUE_WIDTH:0]   MIN_X   = (VALUE_WIDTH+1)'(VALUE_MIN);
    localparam logic [VALUE_WIDTH:0]   MAX_X   = (VALUE_WIDTH+1)'(VALUE_MAX);
    localparam logic [VALUE_WIDTH:0]   RANGE_X = (VALUE_WIDTH+1)'(VALUE_MAX - VALUE_MIN + 1);
    localparam logic [VALUE_WIDTH:0]   ONE_X   = (VALUE_WIDTH+1)'(1);

    logic [VALUE_WIDTH-1:0] value_q, value_d;
    logic                   changed_q, changed_d;
    logic [VALUE_WIDTH:0]   step_size;
    logic                   fast;
    logic                   cw;

    assign cw = (i_step_cw == DIR_CW);

`ifdef ROTARY_VALUE_CTRL_ACCEL_EN
    logic step_eff;
    assign step_eff = i_step & ~i_load;

    rotary_accel_tracker #(
        .VALUE_WIDTH (VALUE_WIDTH),
        .FAST_CYCLES (FAST_CYCLES),
        .STREAK_LEN  (STREAK_LEN),
        .ACCEL_STEP  (ACCEL_STEP)
    ) u_accel (
        .clk_i       (i_clk),
        .rst_ni      (i_rst_n),
        .step_i      (step_eff),
        .dir_i       (i_step_cw),
        .clear_i     (i_load),
        .step_size_o (step_size),
        .fast_o      (fast)
    );
`else
    assign step_size = ONE_X;
    assign fast      = 1'b0;
`endif

    // All range arithmetic is one bit wider than the value so that neither the
    // sum nor the offset-plus-range term can overflow or underflow.
    logic [VALUE_WIDTH:0] val_x, off_x, load_x;
    logic [VALUE_WIDTH:0] up_x, wrap_up_x;
    logic [VALUE_WIDTH:0] sat_up_x, sat_dn_x, wrap_inc_x, wrap_dec_x;
    logic [VALUE_WIDTH:0] load_clamp_x, next_x;

    assign val_x     = {1'b0, value_q};
    assign off_x     = val_x - MIN_X;
    assign load_x    = {1'b0, i_load_value};
    assign up_x      = val_x + step_size;
    assign wrap_up_x = off_x + step_size;

    assign sat_up_x   = (up_x > MAX_X) ? MAX_X : up_x;
    assign sat_dn_x   = (off_x >= step_size) ? val_x - step_size : MIN_X;
    assign wrap_inc_x = MIN_X + ((wrap_up_x >= RANGE_X) ? wrap_up_x - RANGE_X : wrap_up_x);
    assign wrap_dec_x = MIN_X + ((off_x >= step_size) ? off_x - step_size
                                                      : off_x + RANGE_X - step_size);

    assign load_clamp_x = (load_x + ONE_X <= MIN_X) ? MIN_X :
                          (load_x > MAX_X)          ? MAX_X : load_x;

    always_comb begin
        next_x = val_x;
        if (i_load) begin
            next_x = load_clamp_x;
        end else if (i_step) begin
            if (WRAP != 0) next_x = cw ? wrap_inc_x : wrap_dec_x;
            else           next_x = cw ? sat_up_x   : sat_dn_x;
        end
    end

    assign value_d   = next_x[VALUE_WIDTH-1:0];
    assign changed_d = (next_x != val_x);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            value_q   <= INIT_V;
            changed_q <= 1'b0;
        end else begin
            value_q   <= value_d;
            changed_q <= changed_d;
        end
    end

    assign o_value   = value_q;
    assign o_changed = changed_q;
    assign o_at_min  = (value_q == MIN_V);
    assign o_at_max  = (value_q == MAX_V);
    assign o_fast    = fast;

endmodule

// File: tb/tb_rotary_value_ctrl.sv
// Bench for rotary_value_ctrl: a saturating and a wrapping instance share the
// same directed stimulus and are checked each cycle against an elapsed-time model.
module tb_rotary_value_ctrl;
    import rotary_pkg::*;

    localparam int W    = 4;
    localparam int VMIN = 2;
    localparam int VMAX = 10;
    localparam int VINI = 2;
    localparam int FC   = 8;
    localparam int SL   = 2;
    localparam int AS   = 4;
    localparam int NEVER = -1000000;
`ifdef ROTARY_VALUE_CTRL_ACCEL_EN
    localparam bit ACCEL_ON = 1'b1;
`else
    localparam bit ACCEL_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n, step, step_cw, load;
    logic [W-1:0] load_value;
    logic [W-1:0] v0, v1;
    logic ch0, ch1, mn0, mn1, mx0, mx1, f0, f1;

    int n_cmp = 0;
    int n_err = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    rotary_value_ctrl #(
        .VALUE_WIDTH(W), .VALUE_MIN(VMIN), .VALUE_MAX(VMAX), .VALUE_INIT(VINI),
        .WRAP(0), .FAST_CYCLES(FC), .STREAK_LEN(SL), .ACCEL_STEP(AS)
    ) dut_sat (
        .i_clk(clk), .i_rst_n(rst_n), .i_step(step), .i_step_cw(step_cw),
        .i_load(load), .i_load_value(load_value), .o_value(v0), .o_changed(ch0),
        .o_at_min(mn0), .o_at_max(mx0), .o_fast(f0)
    );

    rotary_value_ctrl #(
        .VALUE_WIDTH(W), .VALUE_MIN(VMIN), .VALUE_MAX(VMAX), .VALUE_INIT(VINI),
        .WRAP(1), .FAST_CYCLES(FC), .STREAK_LEN(SL), .ACCEL_STEP(AS)
    ) dut_wrap (
        .i_clk(clk), .i_rst_n(rst_n), .i_step(step), .i_step_cw(step_cw),
        .i_load(load), .i_load_value(load_value), .o_value(v1), .o_changed(ch1),
        .o_at_min(mn1), .o_at_max(mx1), .o_fast(f1)
    );

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int m_val[2], m_streak[2], m_last[2];
    bit m_fast[2], m_dir[2], m_chg[2];
    int cyc = 0;

    function automatic int mdl_next(input int v, input int s, input bit up, input bit wrap);
        int r, t;
        r = VMAX - VMIN + 1;
        if (wrap) begin
            t = (v - VMIN + (up ? s : -s)) % r;
            return VMIN + ((t + r) % r);
        end
        if (up) return (v + s > VMAX) ? VMAX : v + s;
        return (v - s < VMIN) ? VMIN : v - s;
    endfunction

    function automatic int mdl_clamp(input int v);
        return (v < VMIN) ? VMIN : (v > VMAX) ? VMAX : v;
    endfunction

    task automatic mdl_edge(input int k);
        int nv, s;
        bit hit;
        nv = m_val[k];
        if (!rst_n) begin
            m_val[k] = VINI; m_fast[k] = 0; m_streak[k] = 0;
            m_last[k] = NEVER; m_dir[k] = 1'b1; m_chg[k] = 0;
            return;
        end
        if (load) begin
            nv = mdl_clamp(int'(load_value));
            m_streak[k] = 0; m_fast[k] = 0; m_last[k] = NEVER;
        end else if (step) begin
            s = 1;
            hit = (cyc - 1 - m_last[k] < FC) && (step_cw == m_dir[k]);
            if (ACCEL_ON && hit) begin
                if (m_fast[k]) s = AS;
                m_streak[k] = (m_streak[k] + 1 > SL) ? SL : m_streak[k] + 1;
                if (m_streak[k] == SL) m_fast[k] = 1;
            end else begin
                m_streak[k] = 0; m_fast[k] = 0;
            end
            m_dir[k] = step_cw;
            m_last[k] = cyc;
            nv = mdl_next(m_val[k], s, step_cw, k == 1);
        end else if (cyc - m_last[k] >= FC) begin
            m_fast[k] = 0; m_streak[k] = 0;
        end
        m_chg[k] = (nv != m_val[k]);
        m_val[k] = nv;
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
        mdl_edge(0);
        mdl_edge(1);
    end

    task automatic cmp_inst(input int k, input int v, input bit ch, input bit mn,
                            input bit mx, input bit f);
        string p;
        p = (k == 0) ? "sat" : "wrap";
        chk({p, ".value"},   v,  m_val[k]);
        chk({p, ".changed"}, ch, m_chg[k]);
        chk({p, ".at_min"},  mn, m_val[k] == VMIN);
        chk({p, ".at_max"},  mx, m_val[k] == VMAX);
        chk({p, ".fast"},    f,  m_fast[k]);
    endtask

    initial forever begin
        @(negedge clk);
        if (cmp_en) begin
            cmp_inst(0, int'(v0), ch0, mn0, mx0, f0);
            cmp_inst(1, int'(v1), ch1, mn1, mx1, f1);
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic step_pulse(input logic dir);
        step = 1'b1; step_cw = dir;
        @(negedge clk);
        step = 1'b0;
    endtask

    task automatic load_pulse(input int v, input bit with_step);
        load = 1'b1; load_value = W'(v); step = with_step; step_cw = DIR_CW;
        @(negedge clk);
        load = 1'b0; step = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; step = 1'b0; step_cw = DIR_CCW; load = 1'b0; load_value = '0;
        idle(2);
        rst_n = 1'b1;
        cmp_en = 1'b1;

        // reset state
        idle(5);
        chk("t1.value", int'(v0), 2);
        chk("t1.at_min", mn0, 1);
        chk("t1.at_max", mx0, 0);
        chk("t1.changed", ch0, 0);
        chk("t1.fast", f0, 0);

        // slow steps
        for (int i = 0; i < 3; i++) begin
            step_pulse(DIR_CW);
            chk("t2.value", int'(v0), 3 + i);
            chk("t2.changed", ch0, 1);
            idle(1);
            chk("t2.changed_off", ch0, 0);
            chk("t2.fast", f0, 0);
            idle(18);
        end

        // fast steps from 2
        load_pulse(2, 0);
        chk("t3.load", int'(v0), 2);
        idle(2);
        for (int i = 0; i < 5; i++) begin
            step_pulse(DIR_CW);
            chk("t3.value", int'(v0), (ACCEL_ON && i >= 3) ? ((i == 3) ? 9 : 10) : 3 + i);
            chk("t3.fast", f0, (ACCEL_ON && i >= 2) ? 1 : 0);
            if (i == 4) begin
                chk("t3.at_max", mx0, ACCEL_ON ? 1 : 0);
                chk("t3.wrap_value", int'(v1), ACCEL_ON ? 4 : 7);
            end
            idle(2);
        end

        // direction reversal drops out of FAST
        step_pulse(DIR_CCW);
        chk("t4.value", int'(v0), ACCEL_ON ? 9 : 6);
        chk("t4.fast", f0, 0);
        chk("t4.wrap_value", int'(v1), ACCEL_ON ? 3 : 6);
        idle(20);
        step_pulse(DIR_CW);
        chk("t4.value2", int'(v0), ACCEL_ON ? 10 : 7);
        idle(2);
        step_pulse(DIR_CW);
        chk("t4.value3", int'(v0), ACCEL_ON ? 10 : 8);
        chk("t4.changed3", ch0, ACCEL_ON ? 0 : 1);
        chk("t4.fast3", f0, 0);

        // bounds: saturate vs wrap
        idle(2);
        load_pulse(10, 0);
        chk("t5.load_sat", int'(v0), 10);
        chk("t5.load_sat_changed", ch0, ACCEL_ON ? 0 : 1);
        chk("t5.load_wrap", int'(v1), 10);
        idle(1);
        step_pulse(DIR_CW);
        chk("t5.sat_value", int'(v0), 10);
        chk("t5.sat_changed", ch0, 0);
        chk("t5.wrap_value", int'(v1), 2);
        chk("t5.wrap_changed", ch1, 1);
        chk("t5.wrap_at_min", mn1, 1);
        idle(2);
        step_pulse(DIR_CCW);
        chk("t5.wrap_under", int'(v1), 10);
        chk("t5.sat_down", int'(v0), 9);

        // load priority and clamping
        idle(2);
        load_pulse(15, 1);
        chk("t6.load_hi", int'(v0), 10);
        chk("t6.load_hi_changed", ch0, 1);
        chk("t6.load_hi_wrap", int'(v1), 10);
        load_pulse(0, 0);
        chk("t6.load_lo", int'(v0), 2);
        idle(2);
        for (int i = 0; i < 3; i++) begin
            step_pulse(DIR_CW);
            chk("t6.ramp", int'(v0), 3 + i);
            idle(2);
        end
        chk("t6.fast_before_rst", f0, ACCEL_ON ? 1 : 0);

        // reset mid-stream with a step that must be ignored
        rst_n = 1'b0; step = 1'b1; step_cw = DIR_CW;
        @(negedge clk);
        chk("t6.rst_value", int'(v0), 2);
        chk("t6.rst_fast", f0, 0);
        chk("t6.rst_changed", ch0, 0);
        step = 1'b0; rst_n = 1'b1;
        idle(3);
        chk("t6.after_rst", int'(v0), 2);
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
